dcache_ctrl: RTL
================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU MEM stage (EX_MEM result as address, forwarded Rt as store data) and off-chip data memory.
- Hits complete in the same cycle with no stall.
- Misses raise stall_o, which freezes every pipeline register and the PC, while an FSM evicts the dirty victim and refills the 256-bit line over a req/ack memory handshake.

Parameters:
- INDEX_W, 5, line index bits; NUM_LINES = 2**INDEX_W.
- TAG_W, 32-5-INDEX_W (22), tag bits; derived, not overridden.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- cpu_req_i  in  1  MEM-stage access valid (MemRead | MemWrite).
- cpu_write_i  in  1  1 = store, 0 = load.
- cpu_addr_i  in  32  byte address; [1:0] ignored, [4:2] word select, [4+INDEX_W:5] index, [31:5+INDEX_W] tag.
- cpu_wdata_i  in  32  store data.
- cpu_rdata_o  out  32  load data, valid when cpu_req_i & ~stall_o.
- stall_o  out  1  pipeline freeze.
- mem_req_o  out  1  memory request, held until ack.
- mem_write_o  out  1  1 = writeback, 0 = line fetch.
- mem_addr_o  out  32  line-aligned address ([4:0] = 0).
- mem_wdata_o  out  256  victim line.
- mem_rdata_i  in  256  fetched line, valid with mem_ack_i.
- mem_ack_i  in  1  one-cycle completion pulse.

Behaviour:
- Storage: per line one valid bit, one dirty bit, a TAG_W tag and 256 data bits, all in flops. Word w of a line occupies bits [32w+31:32w].
- hit = valid[idx] & (tag[idx] == addr tag).
- States: IDLE, WB, FETCH, FILL.
- IDLE:
  - cpu_req_i & hit & ~cpu_write_i: cpu_rdata_o = word, combinational, same cycle; stall_o = 0.
  - cpu_req_i & hit & cpu_write_i: the word is written at the clock edge and dirty is set; stall_o = 0.
  - cpu_req_i & ~hit: stall_o = 1 combinationally. Next state is WB if valid & dirty, else FETCH.
  - ~cpu_req_i: stall_o = 0, no state change.
- WB:
  - mem_req_o = 1, mem_write_o = 1.
  - mem_addr_o = {stored tag, idx, 5'b0}; mem_wdata_o = stored line.
  - On mem_ack_i go to FETCH.
- FETCH:
  - mem_req_o = 1, mem_write_o = 0, mem_addr_o = {addr tag, idx, 5'b0}.
  - On mem_ack_i, capture mem_rdata_i into the line: valid = 1, dirty = 0, tag updated. Go to FILL.
- FILL: one cycle, no memory request, then IDLE. In IDLE the access now hits and completes: stall_o drops and a store is merged at that edge.
- stall_o = 1 in WB, FETCH and FILL, regardless of cpu_req_i.
- The CPU holds address, data and request stable while stalled. The cache registers the miss index and tag on entering WB/FETCH and uses the registered copies thereafter.
- mem_req_o, mem_write_o, mem_addr_o and mem_wdata_o are stable from the cycle of request until the ack cycle inclusive. mem_req_o is deasserted the cycle after the ack. mem_ack_i is ignored in IDLE and FILL.
- Miss latency with memory ack latency L cycles:
  - clean miss: stall = L+2 cycles;
  - dirty miss: 2L+2 cycles.
- Reset, including mid-miss:
  - state = IDLE; all valid and dirty bits cleared; the pending miss is dropped with no writeback.
  - Outputs: mem_req_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_wdata_o = 0, cpu_rdata_o = 0 when there is no hit.
  - stall_o follows the IDLE rule.
  - Data and tag arrays need not reset.
- Index aliasing: a load and a store to the same line on consecutive cycles see the store (write-before-read ordering through the flop array).

Optional Feature:
- Macro DCACHE_STATS_EN.
- When defined, adds outputs hit_cnt_o [31:0] and miss_cnt_o [31:0], both reset to 0.
  - hit_cnt_o increments once per IDLE hit that completes with stall_o = 0. The completing access after FILL counts as a miss, not a hit.
  - miss_cnt_o increments once on each IDLE→WB or IDLE→FETCH transition.
  - Both counters wrap from 0xFFFFFFFF to 0.
- When undefined, neither port nor counter logic exists.

Test Plan:
- Reset, then load 0x0000_0040 with memory returning a line whose word0 = 0x1234_5678 after L = 4 -> mem_write_o = 0, mem_addr_o = 0x40, stall_o high for 6 cycles, then cpu_rdata_o = 0x1234_5678.
- Store 0xDEAD_BEEF to 0x44, then load 0x44 -> both complete with no stall; load returns 0xDEAD_BEEF; no memory request.
- Load 0x0000_0440 (same index 2, tag 1) after the dirty store -> WB with mem_addr_o = 0x40 and mem_wdata_o[63:32] = 0xDEAD_BEEF, then FETCH at 0x440; stall = 2L+2 = 10 cycles.
- Hold mem_ack_i low 20 cycles in FETCH -> mem_req_o and mem_addr_o stay constant, stall_o stays 1; a spurious mem_ack_i pulse while in IDLE is ignored.
- Assert rst_i during WB -> next cycle mem_req_o = 0 and state = IDLE; reload 0x40 misses (valid cleared) and triggers FETCH, not WB.
- DCACHE_STATS_EN: 3 misses and 5 hits -> miss_cnt_o = 3, hit_cnt_o = 5.

Source files
------------

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate data cache controller; optional hit/miss counters under DCACHE_STATS_EN
module dcache_ctrl #(
    parameter int INDEX_W = 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cpu_req_i,
    input  logic         cpu_write_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_wdata_i,
    output logic [31:0]  cpu_rdata_o,
    output logic         stall_o,
    output logic         mem_req_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_wdata_o,
    input  logic [255:0] mem_rdata_i,
    input  logic         mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]  hit_cnt_o,
    output logic [31:0]  miss_cnt_o
`endif
);

    localparam int TAG_W     = 32 - 5 - INDEX_W;
    localparam int NUM_LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WB    = 2'd1,
        S_FETCH = 2'd2,
        S_FILL  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // line storage: status bits are reset, tag and data are not
    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [255:0]         r_data [NUM_LINES];

    // miss context, frozen for the whole refill
    logic [INDEX_W-1:0]   r_miss_idx;
    logic [TAG_W-1:0]     r_miss_tag;

    logic [INDEX_W-1:0]   w_idx;
    logic [TAG_W-1:0]     w_tag;
    logic [2:0]           w_word;
    logic [255:0]         w_line;
    logic                 w_hit;
    logic                 w_miss_start;
    logic                 w_store_hit;
    logic                 w_fill;
    logic [1:0]           w_unused_addr_bits;

    assign w_idx              = cpu_addr_i[4+INDEX_W:5];
    assign w_tag              = cpu_addr_i[31:5+INDEX_W];
    assign w_word             = cpu_addr_i[4:2];
    assign w_unused_addr_bits = cpu_addr_i[1:0];
    assign w_line             = r_data[w_idx];
    assign w_hit              = r_valid[w_idx] & (r_tag[w_idx] == w_tag);

    // a store merges only while idle; a refill lands when the fetch is acknowledged
    assign w_store_hit = (r_state == S_IDLE) & cpu_req_i & cpu_write_i & w_hit;
    assign w_fill      = (r_state == S_FETCH) & mem_ack_i;

    // load data straight from the flop array so hits need no extra cycle
    always_comb begin
        cpu_rdata_o = '0;
        if (w_hit) begin
            cpu_rdata_o = w_line[{w_word, 5'b0} +: 32];
        end
    end

    // next-state and memory-side outputs; outputs depend only on state and registered miss context
    always_comb begin
        w_state_nxt  = r_state;
        stall_o      = 1'b0;
        mem_req_o    = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        w_miss_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cpu_req_i && !w_hit) begin
                    stall_o      = 1'b1;
                    w_miss_start = 1'b1;
                    if (r_valid[w_idx] && r_dirty[w_idx]) begin
                        w_state_nxt = S_WB;
                    end else begin
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_WB: begin
                stall_o     = 1'b1;
                mem_req_o   = 1'b1;
                mem_write_o = 1'b1;
                mem_addr_o  = {r_tag[r_miss_idx], r_miss_idx, 5'b0};
                mem_wdata_o = r_data[r_miss_idx];
                if (mem_ack_i) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                stall_o    = 1'b1;
                mem_req_o  = 1'b1;
                mem_addr_o = {r_miss_tag, r_miss_idx, 5'b0};
                if (mem_ack_i) begin
                    w_state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                stall_o     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // capture the missing index and tag as the refill starts
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_miss_idx <= '0;
            r_miss_tag <= '0;
        end else if (w_miss_start) begin
            r_miss_idx <= w_idx;
            r_miss_tag <= w_tag;
        end
    end

    // valid/dirty: cleared on reset so any pending miss is dropped without writeback
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (w_fill) begin
            r_valid[r_miss_idx] <= 1'b1;
            r_dirty[r_miss_idx] <= 1'b0;
        end else if (w_store_hit) begin
            r_dirty[w_idx] <= 1'b1;
        end
    end

    // tag and data arrays: whole-line refill or single-word store merge
    always_ff @(posedge clk_i) begin
        if (w_fill) begin
            r_data[r_miss_idx] <= mem_rdata_i;
            r_tag[r_miss_idx]  <= r_miss_tag;
        end else if (w_store_hit) begin
            r_data[w_idx][{w_word, 5'b0} +: 32] <= cpu_wdata_i;
        end
    end

`ifdef DCACHE_STATS_EN
    logic r_fill_done;
    logic w_count_hit;

    // the access completing right after a refill was already counted as a miss
    assign w_count_hit = (r_state == S_IDLE) & cpu_req_i & w_hit & ~r_fill_done;

    // remember that the previous cycle was FILL
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fill_done <= 1'b0;
        end else begin
            r_fill_done <= (r_state == S_FILL);
        end
    end

    // free-running wrapping hit/miss counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            if (w_count_hit) begin
                hit_cnt_o <= hit_cnt_o + 32'd1;
            end
            if (w_miss_start) begin
                miss_cnt_o <= miss_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule
